// File: rtl/sender_scheduler_if.sv
// ---------------------------------------------------------------------------
// sender_scheduler_if
// Bundles the requester handshakes, the sender datapath connection and the
// serial transmit outputs of sender_scheduler.
//
// Handshake rule: a word moves on a cycle where reqN_valid && reqN_ready are
// both high at the rising clock edge. valid may rise or fall at any time.
// ready is combinational. It may be high only while the scheduler is idle,
// and at most one ready is high at a time. The serial transmit side has no
// backpressure: every cycle with tx_valid high carries one bit.
//
// Signals:
//   req0_valid/req0_data/req0_ready : requester 0 handshake
//   req1_valid/req1_data/req1_ready : requester 1 handshake
//   snd_data  : registered word into the external sender datapath
//   snd_out   : sender frame, a combinational function of snd_data
//   tx_bit/tx_valid/tx_last/tx_src : serial output, MSB first
//   busy      : scheduler not idle
//   state_dbg : raw FSM state, for checkers
// Modports: slave = scheduler side, master = producer/link side.
// ---------------------------------------------------------------------------
interface sender_scheduler_if #(
  parameter int DATA_W  = 32,
  parameter int FRAME_W = 48
);
  logic               req0_valid;
  logic [DATA_W-1:0]  req0_data;
  logic               req0_ready;
  logic               req1_valid;
  logic [DATA_W-1:0]  req1_data;
  logic               req1_ready;
  logic [DATA_W-1:0]  snd_data;
  logic [FRAME_W-1:0] snd_out;
  logic               tx_bit;
  logic               tx_valid;
  logic               tx_last;
  logic               tx_src;
  logic               busy;
  logic [1:0]         state_dbg;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, snd_out,
    output req0_ready, req1_ready, snd_data, tx_bit, tx_valid, tx_last,
           tx_src, busy, state_dbg
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, snd_out,
    input  req0_ready, req1_ready, snd_data, tx_bit, tx_valid, tx_last,
           tx_src, busy, state_dbg
  );
endinterface

// File: rtl/sender_scheduler.sv
// ---------------------------------------------------------------------------
// sender_scheduler
// Arbitrates two word producers with a round-robin pointer. It registers the
// granted word into a shared external checksum datapath ("sender") and
// captures the resulting frame. It then shifts the frame out MSB-first on a
// one-bit line with valid/last strobes. One frame takes 50 cycles from
// handshake to the next possible handshake.
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : sender_scheduler_if.slave (requesters, sender link, tx outputs,
//         busy, state_dbg)
// ---------------------------------------------------------------------------
module sender_scheduler #(
  parameter int DATA_W  = 32,
  parameter int FRAME_W = 48,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  sender_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

  state_t             state_q, state_d;
  logic               rr_q, rr_d;
  logic [DATA_W-1:0]  snd_data_q, snd_data_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               src_q, src_d;
  logic               tx_bit_q, tx_bit_d;
  logic               tx_valid_q, tx_valid_d;
  logic               tx_last_q, tx_last_d;
  logic               busy_q, busy_d;

  logic               idle;
  logic               grant0;
  logic               grant1;
  logic [CNT_W-1:0]   cnt_inc;

  // A lone valid requester always wins. rr_q only breaks ties.
  assign idle    = (state_q == S_IDLE);
  assign grant0  = idle && bus.req0_valid && (!bus.req1_valid || !rr_q);
  assign grant1  = idle && bus.req1_valid && (!bus.req0_valid ||  rr_q);
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_q       <= 1'b0;
      snd_data_q <= '0;
      frame_q    <= '0;
      cnt_q      <= '0;
      src_q      <= 1'b0;
      tx_bit_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      snd_data_q <= snd_data_d;
      frame_q    <= frame_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      tx_bit_q   <= tx_bit_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    snd_data_d = snd_data_q;
    frame_d    = frame_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    tx_bit_d   = tx_bit_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE: begin
        if (grant0) begin
          snd_data_d = bus.req0_data;
          src_d      = 1'b0;
          rr_d       = 1'b1;
          state_d    = S_LOAD;
          busy_d     = 1'b1;
        end else if (grant1) begin
          snd_data_d = bus.req1_data;
          src_d      = 1'b1;
          rr_d       = 1'b0;
          state_d    = S_LOAD;
          busy_d     = 1'b1;
        end
      end

      // snd_out has settled from snd_data. Capture the frame and present
      // its MSB right away, so the tx outputs stay registered and aligned
      // with cnt.
      S_LOAD: begin
        frame_d    = bus.snd_out;
        cnt_d      = '0;
        tx_valid_d = 1'b1;
        tx_bit_d   = bus.snd_out[FRAME_W-1];
        tx_last_d  = 1'b0;
        state_d    = S_SHIFT;
      end

      // cnt_q names the bit on the line this cycle. Prepare the next one.
      S_SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
          tx_bit_d   = 1'b0;
          tx_last_d  = 1'b0;
          busy_d     = 1'b0;
        end else begin
          cnt_d     = cnt_inc;
          tx_bit_d  = frame_q[LAST_CNT - cnt_inc];
          tx_last_d = (cnt_inc == LAST_CNT);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.snd_data   = snd_data_q;
  assign bus.tx_bit     = tx_bit_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_last    = tx_last_q;
  assign bus.tx_src     = src_q;
  assign bus.busy       = busy_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_sender_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sender_scheduler
// Directed bench for sender_scheduler. A frame-level model predicts every
// output from the cycle count since the last handshake. Hand-computed frame
// literals pin both the model and the external sender function.
// ---------------------------------------------------------------------------
module tb_sender_scheduler;
  localparam int DATA_W  = 32;
  localparam int FRAME_W = 48;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sender_scheduler_if #(.DATA_W(DATA_W), .FRAME_W(FRAME_W)) bus();

  sender_scheduler #(.DATA_W(DATA_W), .FRAME_W(FRAME_W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External sender datapath: the word followed by a 16-bit folded XOR.
  logic              force_en  = 1'b0;
  logic [FRAME_W-1:0] force_val = '0;

  function automatic logic [47:0] sender_fn(input logic [31:0] d);
    return {d, d[31:16] ^ d[15:0]};
  endfunction

  assign bus.snd_out = force_en ? force_val : sender_fn(bus.snd_data);

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timeout at cycle %0d", name, cyc);
  endtask

  // ---------------- model ----------------
  // m_k = cycles since the handshake edge (1 = LOAD, 2..49 = bits), -1 idle.
  int          m_k     = -1;
  logic        m_rr    = 1'b0;
  logic [31:0] m_word  = '0;
  logic [47:0] m_frame = '0;
  logic        m_src   = 1'b0;

  function automatic logic [1:0] model_grant();
    if (m_k >= 0) return 2'b00;
    if (bus.req0_valid && bus.req1_valid) return m_rr ? 2'b10 : 2'b01;
    return {bus.req1_valid, bus.req0_valid};
  endfunction

  initial forever begin
    logic [1:0] g;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_k = -1; m_rr = 1'b0; m_word = '0; m_frame = '0; m_src = 1'b0;
    end else if (m_k < 0) begin
      g = model_grant();
      if (g[0]) begin
        m_word = bus.req0_data; m_src = 1'b0; m_rr = 1'b1; m_k = 1;
        m_frame = force_en ? force_val : sender_fn(bus.req0_data);
      end else if (g[1]) begin
        m_word = bus.req1_data; m_src = 1'b1; m_rr = 1'b0; m_k = 1;
        m_frame = force_en ? force_val : sender_fn(bus.req1_data);
      end
    end else begin
      m_k = (m_k == 49) ? -1 : m_k + 1;
    end
  end

  // ---------------- handshake monitor ----------------
  logic hs_src[$];
  int   hs_cyc[$];

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      if (bus.req0_valid && bus.req0_ready) begin hs_src.push_back(1'b0); hs_cyc.push_back(cyc); end
      if (bus.req1_valid && bus.req1_ready) begin hs_src.push_back(1'b1); hs_cyc.push_back(cyc); end
    end
    cyc++;
  end

  // ---------------- compare + frame collector ----------------
  logic [47:0] exp_q[$];      // expected frames, pushed by the directed tests
  logic [47:0] frames_q[$];
  logic        srcs_q[$];
  int          nbits_q[$];
  int          last_cyc_q[$];
  logic [47:0] rx_sh = '0;
  int          rx_n  = 0;

  initial forever begin
    logic [1:0] g;
    logic       eb;
    @(negedge clk);
    g  = model_grant();
    eb = 1'b0;
    if (m_k >= 2) eb = m_frame[49 - m_k];
    check("req0_ready", 64'(bus.req0_ready), 64'(g[0]));
    check("req1_ready", 64'(bus.req1_ready), 64'(g[1]));
    check("busy",       64'(bus.busy),       64'(m_k >= 0));
    check("snd_data",   64'(bus.snd_data),   64'(m_word));
    check("tx_valid",   64'(bus.tx_valid),   64'(m_k >= 2));
    check("tx_bit",     64'(bus.tx_bit),     64'(eb));
    check("tx_last",    64'(bus.tx_last),    64'(m_k == 49));
    check("tx_src",     64'(bus.tx_src),     64'(m_src));
    if (rst) begin
      rx_n = 0;
    end else if (bus.tx_valid) begin
      rx_sh = {rx_sh[46:0], bus.tx_bit};
      rx_n++;
      if (bus.tx_last) begin
        frames_q.push_back(rx_sh);
        srcs_q.push_back(bus.tx_src);
        nbits_q.push_back(rx_n);
        last_cyc_q.push_back(cyc);
        rx_n = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    bus.req0_valid = v0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_data = d1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic clear_logs();
    hs_src.delete(); hs_cyc.delete();
    frames_q.delete(); srcs_q.delete(); nbits_q.delete(); last_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_hs(input int n, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (hs_src.size() >= n) break;
    end
    if (i == budget) timeout(name);
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frames_q.size() >= n) break;
    end
    if (i == budget) timeout(name);
  endtask

  // Pops received frames against exp_q and the given source list.
  task automatic score_frames(input string name, input logic [2:0] srcs, input int n);
    for (int i = 0; i < n; i++) begin
      if (frames_q.size() == 0 || exp_q.size() == 0) begin
        timeout({name, "_frame_missing"});
      end else begin
        check({name, "_frame"}, 64'(frames_q.pop_front()), 64'(exp_q.pop_front()));
        check({name, "_src"},   64'(srcs_q.pop_front()),   64'(srcs[i]));
        check({name, "_nbits"}, 64'(nbits_q.pop_front()),  64'd48);
      end
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.req0_valid = 1'b0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",     64'(bus.busy),     64'd0);
    check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("rst_snd_data", 64'(bus.snd_data), 64'd0);
    check("rst_tx_src",   64'(bus.tx_src),   64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // T1: single req0 word, timing and bit order
    clear_logs();
    exp_q.push_back(48'h9D2DC3D55EF8);
    drive(1'b1, 32'h9D2DC3D5, 1'b0, 32'h0);
    wait_hs(1, 10, "t1_hs");
    check("t1_snd_data", 64'(bus.snd_data), 64'h9D2DC3D5);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    wait_frames(1, 100, "t1_frame");
    if (hs_cyc.size() > 0 && last_cyc_q.size() > 0)
      check("t1_last_latency", 64'(last_cyc_q[0] - hs_cyc[0]), 64'd49);
    score_frames("t1", 3'b000, 1);

    // T2: both valid from reset, alternating grants
    do_reset();
    clear_logs();
    exp_q.push_back(48'h000000010001);
    exp_q.push_back(48'hFFFFFFFF0000);
    exp_q.push_back(48'h000000010001);
    drive(1'b1, 32'h00000001, 1'b1, 32'hFFFFFFFF);
    wait_hs(3, 200, "t2_hs");
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    wait_frames(3, 200, "t2_frame");
    if (hs_cyc.size() >= 3) begin
      check("t2_hs_gap0", 64'(hs_cyc[1] - hs_cyc[0]), 64'd50);
      check("t2_hs_gap1", 64'(hs_cyc[2] - hs_cyc[1]), 64'd50);
      check("t2_hs_src1", 64'(hs_src[1]), 64'd1);
    end
    score_frames("t2", 3'b010, 3);

    // T3: req1 alone after reset wins, then rr points back to req0
    do_reset();
    clear_logs();
    exp_q.push_back(48'h000000000000);
    drive(1'b0, 32'h0, 1'b1, 32'h00000000);
    wait_hs(1, 10, "t3_hs");
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    wait_frames(1, 100, "t3_frame");
    score_frames("t3", 3'b001, 1);
    exp_q.push_back(48'h000000020002);
    drive(1'b1, 32'h00000002, 1'b1, 32'h00000003);
    wait_hs(2, 10, "t3_hs2");
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    if (hs_src.size() >= 2) check("t3_rr_back_to_0", 64'(hs_src[1]), 64'd0);
    wait_frames(1, 100, "t3_frame2");
    score_frames("t3b", 3'b000, 1);

    // T4: inputs change during SHIFT and are ignored
    clear_logs();
    exp_q.push_back(48'hA5A50F0FAAAA);
    drive(1'b1, 32'hA5A50F0F, 1'b0, 32'h0);
    wait_hs(1, 10, "t4_hs");
    for (int i = 0; i < 20; i++)
      drive(1'b1, 32'h1111_1111 * (i + 1), 1'b1, 32'hDEAD_0000 + i);
    check("t4_snd_hold", 64'(bus.snd_data), 64'hA5A50F0F);
    wait_frames(1, 100, "t4_frame");
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    check("t4_no_extra_hs", 64'(hs_src.size()), 64'd1);
    score_frames("t4", 3'b000, 1);

    // T5: reset at bit 20 aborts the frame, rr returns to req0
    clear_logs();
    drive(1'b1, 32'h12345678, 1'b0, 32'h0);
    wait_hs(1, 10, "t5_hs");
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    begin
      int i;
      for (i = 0; i < 100; i++) begin
        @(negedge clk);
        if (rx_n >= 20) break;
      end
      if (i == 100) timeout("t5_bit20");
    end
    #2 rst = 1'b1;
    #1;
    check("t5_abort_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("t5_abort_tx_last",  64'(bus.tx_last),  64'd0);
    check("t5_abort_busy",     64'(bus.busy),     64'd0);
    check("t5_abort_snd_data", 64'(bus.snd_data), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_no_frame", 64'(frames_q.size()), 64'd0);
    clear_logs();
    exp_q.push_back(48'hCAFEF00D3AF3);
    drive(1'b1, 32'hCAFEF00D, 1'b1, 32'h0BADBEEF);
    wait_hs(1, 10, "t5_hs2");
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    if (hs_src.size() >= 1) check("t5_rr_reset", 64'(hs_src[0]), 64'd0);
    wait_frames(1, 100, "t5_frame");
    score_frames("t5", 3'b000, 1);

    // T6: forced sender output with only the LSB set
    clear_logs();
    force_val = 48'h000000000001;
    force_en  = 1'b1;
    exp_q.push_back(48'h000000000001);
    drive(1'b1, 32'h55AA55AA, 1'b0, 32'h0);
    wait_hs(1, 10, "t6_hs");
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    wait_frames(1, 100, "t6_frame");
    score_frames("t6", 3'b000, 1);
    repeat (2) @(negedge clk);
    force_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sender_scheduler.md
Name: sender_scheduler

Overview:
- Shares one combinational `sender` checksum datapath (32-bit data in, 48-bit frame out) between two requesters.
- Round-robin arbitration between the requesters.
- Registers the accepted word and presents it to the sender.
- Captures the resulting 48-bit frame and serializes it MSB-first onto a one-bit transmit line with framing strobes.
- Sits between the word producers and the physical serial link.

Parameters:
- DATA_W, 32, width of a requester word and of the sender data input
- FRAME_W, 48, width of the sender output frame (data plus checksum)
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W >= FRAME_W

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has a word
- req0_data  input  DATA_W  requester 0 word
- req0_ready  output  1  requester 0 word accepted this cycle when valid&&ready
- req1_valid  input  1  requester 1 has a word
- req1_data  input  DATA_W  requester 1 word
- req1_ready  output  1  requester 1 handshake
- snd_data  output  DATA_W  registered word driven into the sender
- snd_out  input  FRAME_W  sender frame output (combinational function of snd_data)
- tx_bit  output  1  serial data bit
- tx_valid  output  1  tx_bit is valid this cycle
- tx_last  output  1  final bit of the frame
- tx_src  output  1  requester index owning the frame being shifted
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: single clock domain; rst is asynchronous, active-high.
- Reset values (all registered):
  - state = IDLE; rr_ptr = 0 (req0 favoured)
  - snd_data = 0; frame = 0; cnt = 0; tx_src = 0
  - tx_bit, tx_valid, tx_last and busy all 0
- State machine:
  - IDLE -> LOAD on handshake.
  - LOAD -> SHIFT unconditionally after one cycle.
  - SHIFT -> IDLE after the cycle with cnt == FRAME_W-1.
- Arbitration (IDLE only):
  - grant = the valid requester, if exactly one is valid.
  - If both are valid, grant = rr_ptr.
  - reqN_ready = (state == IDLE) && grantN; combinational, at most one high.
  - Both ready are 0 outside IDLE.
- Handshake: on reqN_valid && reqN_ready:
  - snd_data <= reqN_data
  - tx_src <= N
  - rr_ptr <= ~N
  - state <= LOAD
- rr_ptr changes only on a handshake. A requester that drops valid while waiting loses nothing; no state is retained for it.
- LOAD:
  - frame <= snd_out; cnt <= 0; state <= SHIFT.
  - snd_data is held stable from LOAD through the end of SHIFT.
- SHIFT:
  - tx_valid = 1; tx_bit = frame[FRAME_W-1-cnt]; tx_last = (cnt == FRAME_W-1).
  - All three are registered outputs aligned to cnt; no backpressure.
  - cnt increments each cycle. After the last bit: state <= IDLE, tx_valid and tx_last return to 0.
- Latency:
  - Handshake at cycle N; first tx bit valid at cycle N+2; tx_last at N+49.
  - Next handshake possible at N+50.
  - Throughput: one frame per 50 cycles.
- Requester inputs during LOAD and SHIFT are ignored; data is not sampled.
- Both requesters valid continuously: grants alternate 0, 1, 0, 1, ... starting with 0 after reset.
- Reset mid-LOAD or mid-SHIFT:
  - The frame is aborted immediately (async).
  - tx_valid drops with no tx_last.
  - rr_ptr returns to 0.
  - The aborted word is not retransmitted.
- tx_bit = 0 whenever tx_valid = 0.

Test Plan:
- Reset, then req0_valid=1 with req0_data=32'h9D2DC3D5 at cycle N:
  - req0_ready=1 at N; snd_data=32'h9D2DC3D5 from N+1.
  - tx_valid high N+2..N+49; the 48 bits equal the sender frame for that word, MSB first.
  - tx_last only at N+49; tx_src=0.
- Both requesters valid from reset, req0_data=32'h00000001, req1_data=32'hFFFFFFFF:
  - Frames go out req0, req1, req0 (tx_src 0, 1, 0).
  - Handshakes are 50 cycles apart.
- req1 alone valid with data 32'h00000000:
  - req1 is granted even though rr_ptr=0.
  - Frame equals the sender output for zero; rr_ptr becomes 0.
- req0_data changes and req1_valid asserts during SHIFT:
  - No ready asserted during SHIFT.
  - snd_data and frame are unchanged; the transmitted bits are unaffected.
- rst pulsed at bit 20 of a frame:
  - Outputs go to reset values immediately and no tx_last appears.
  - The next handshake goes to req0 when both are valid.
- Frame with a 1 only at the LSB of snd_out (bench-forced snd_out=48'h000000000001): tx_bit is 0 for 47 cycles, then 1 together with tx_last.
